// File: rtl/mole_game_core_if.sv
// Bus interface for mole_game_core.
//   master: start, spawn_tick, switches out; moles, moles_on, points, hits, misses, active, round_done in
//   slave : mirror of master (the core side)
interface mole_game_core_if #(
  parameter int unsigned N_HOLES = 16,
  parameter int unsigned SCORE_W = 11
) ();
  logic               start;
  logic               spawn_tick;
  logic [N_HOLES-1:0] switches;
  logic [N_HOLES-1:0] moles;
  logic [4:0]         moles_on;
  logic [SCORE_W-1:0] points;
  logic [7:0]         hits;
  logic [7:0]         misses;
  logic               active;
  logic               round_done;

  modport master (
    output start, spawn_tick, switches,
    input  moles, moles_on, points, hits, misses, active, round_done
  );

  modport slave (
    input  start, spawn_tick, switches,
    output moles, moles_on, points, hits, misses, active, round_done
  );
endinterface

// File: rtl/mole_game_core.sv
// Whack-a-mole round engine: LFSR mole spawning, mole ageing on spawn_tick,
// switch-toggle hit detection, saturating score/hit/miss counters, round timer.
// Ports:
//   clk_500hz  game clock, all logic on posedge
//   rst_game   synchronous active-high reset
//   bus        mole_game_core_if.slave: start, spawn_tick, switches in;
//              moles, moles_on (popcount of moles), points, hits, misses,
//              active, round_done out
// Build option: define MOLE_PENALTY_EN to charge -1 point (and a miss) for every
// whack on an unlit hole and every expiry; otherwise only expiries count as misses.
module mole_game_core #(
  parameter int unsigned N_HOLES     = 16,
  parameter int unsigned MAX_MOLES   = 4,
  parameter int unsigned MOLE_LIFE   = 3,
  parameter int unsigned ROUND_TICKS = 30,
  parameter int unsigned SCORE_W     = 11,
  parameter int unsigned HIT_POINTS  = 1,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic              clk_500hz,
  input  logic              rst_game,
  mole_game_core_if.slave   bus
);

  localparam int unsigned AGE_W  = (MOLE_LIFE > 1) ? $clog2(MOLE_LIFE + 1) : 1;
  localparam int unsigned TICK_W = (ROUND_TICKS > 1) ? $clog2(ROUND_TICKS + 1) : 1;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned SUM_W  = SCORE_W + 5;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PLAY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(ROUND_TICKS - 1);
  localparam logic [AGE_W-1:0]   AGE_LAST  = AGE_W'(MOLE_LIFE - 1);

  logic [1:0]                    state_q, state_d;
  logic [N_HOLES-1:0]            moles_q, moles_d;
  logic [N_HOLES-1:0][AGE_W-1:0] ages_q, ages_d;
  logic [SCORE_W-1:0]            points_q, points_d;
  logic [7:0]                    hits_q, hits_d;
  logic [7:0]                    misses_q, misses_d;
  logic                          active_q, active_d;
  logic                          round_done_q, round_done_d;
  logic [N_HOLES-1:0]            sw_last_q, sw_last_d;
  logic [15:0]                   lfsr_q, lfsr_d;
  logic [TICK_W-1:0]             tick_cnt_q, tick_cnt_d;

  logic [N_HOLES-1:0]    whack_c, hit_c, exp_c;
  logic [CNT_W-1:0]      moles_on_c, hit_n_c, exp_n_c, pen_n_c, miss_n_c;
  logic                  room_c, go_play_c;
  logic signed [SUM_W-1:0] sum_c;
  logic [SCORE_W-1:0]    points_cl_c;
  logic [8:0]            hits_sum_c, miss_sum_c;
  logic [7:0]            hits_sat_c, miss_sat_c;

  // Per-hole events against pre-edge moles; an expiring hole that is also whacked counts as a hit.
  always_comb begin
    whack_c    = bus.switches ^ sw_last_q;
    hit_c      = '0;
    exp_c      = '0;
    moles_on_c = '0;
    hit_n_c    = '0;
    exp_n_c    = '0;
    for (int i = 0; i < int'(N_HOLES); i++) begin
      hit_c[i]   = moles_q[i] & whack_c[i];
      exp_c[i]   = moles_q[i] & ~whack_c[i] & bus.spawn_tick & (ages_q[i] == AGE_LAST);
      moles_on_c = moles_on_c + CNT_W'(moles_q[i]);
      hit_n_c    = hit_n_c + CNT_W'(hit_c[i]);
      exp_n_c    = exp_n_c + CNT_W'(exp_c[i]);
    end
  end

`ifdef MOLE_PENALTY_EN
  logic [CNT_W-1:0] unlit_n_c;

  // Whacks on dark holes are penalised.
  always_comb begin
    unlit_n_c = '0;
    for (int i = 0; i < int'(N_HOLES); i++) begin
      unlit_n_c = unlit_n_c + CNT_W'(~moles_q[i] & whack_c[i]);
    end
    pen_n_c  = unlit_n_c + exp_n_c;
    miss_n_c = unlit_n_c + exp_n_c;
  end
`else
  // Only expiries are misses; nothing costs points.
  always_comb begin
    pen_n_c  = '0;
    miss_n_c = exp_n_c;
  end
`endif

  // Score delta summed wide and signed, clamped once; counters saturate at 255.
  always_comb begin
    room_c = (moles_on_c - hit_n_c - exp_n_c) < CNT_W'(MAX_MOLES);
    sum_c  = SUM_W'(points_q) + SUM_W'(hit_n_c) * SUM_W'(HIT_POINTS) - SUM_W'(pen_n_c);
    if (sum_c[SUM_W-1]) begin
      points_cl_c = '0;
    end else if (sum_c[SUM_W-2:SCORE_W] != '0) begin
      points_cl_c = SCORE_MAX;
    end else begin
      points_cl_c = sum_c[SCORE_W-1:0];
    end
    hits_sum_c = 9'(hits_q) + 9'(hit_n_c);
    miss_sum_c = 9'(misses_q) + 9'(miss_n_c);
    hits_sat_c = hits_sum_c[8] ? 8'hFF : hits_sum_c[7:0];
    miss_sat_c = miss_sum_c[8] ? 8'hFF : miss_sum_c[7:0];
  end

  // Next-state and datapath update.
  always_comb begin
    state_d      = state_q;
    moles_d      = moles_q;
    ages_d       = ages_q;
    points_d     = points_q;
    hits_d       = hits_q;
    misses_d     = misses_q;
    tick_cnt_d   = tick_cnt_q;
    round_done_d = 1'b0;
    go_play_c    = 1'b0;
    sw_last_d    = bus.switches;
    // Galois LFSR, x^16+x^14+x^13+x^11+1, free-running
    lfsr_d       = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

    case (state_q)
      S_PLAY: begin
        if (bus.start) begin
          go_play_c = 1'b1;
        end else begin
          for (int i = 0; i < int'(N_HOLES); i++) begin
            if (hit_c[i] || exp_c[i]) begin
              moles_d[i] = 1'b0;
              ages_d[i]  = '0;
            end else if (moles_q[i] && bus.spawn_tick) begin
              ages_d[i] = ages_q[i] + AGE_W'(1);
            end else if (bus.spawn_tick && room_c && !moles_q[i] && !whack_c[i] &&
                         (lfsr_q[3:0] == 4'(i))) begin
              moles_d[i] = 1'b1;
              ages_d[i]  = '0;
            end
          end
          points_d = points_cl_c;
          hits_d   = hits_sat_c;
          misses_d = miss_sat_c;
          if (bus.spawn_tick) begin
            if (tick_cnt_q == TICK_LAST) begin
              state_d      = S_DONE;
              round_done_d = 1'b1;
              moles_d      = '0;
              ages_d       = '0;
            end else begin
              tick_cnt_d = tick_cnt_q + TICK_W'(1);
            end
          end
        end
      end
      S_IDLE, S_DONE: begin
        moles_d = '0;
        ages_d  = '0;
        if (bus.start) begin
          go_play_c = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        moles_d = '0;
        ages_d  = '0;
      end
    endcase

    // Round (re)start wipes play state in the same cycle, swallowing any whack.
    if (go_play_c) begin
      state_d    = S_PLAY;
      moles_d    = '0;
      ages_d     = '0;
      points_d   = '0;
      hits_d     = '0;
      misses_d   = '0;
      tick_cnt_d = '0;
    end

    active_d = (state_d == S_PLAY);
  end

  // State registers.
  always_ff @(posedge clk_500hz) begin
    if (rst_game) begin
      state_q      <= S_IDLE;
      moles_q      <= '0;
      ages_q       <= '0;
      points_q     <= '0;
      hits_q       <= '0;
      misses_q     <= '0;
      active_q     <= 1'b0;
      round_done_q <= 1'b0;
      sw_last_q    <= bus.switches;
      lfsr_q       <= LFSR_SEED;
      tick_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      moles_q      <= moles_d;
      ages_q       <= ages_d;
      points_q     <= points_d;
      hits_q       <= hits_d;
      misses_q     <= misses_d;
      active_q     <= active_d;
      round_done_q <= round_done_d;
      sw_last_q    <= sw_last_d;
      lfsr_q       <= lfsr_d;
      tick_cnt_q   <= tick_cnt_d;
    end
  end

  assign bus.moles      = moles_q;
  assign bus.moles_on   = moles_on_c;
  assign bus.points     = points_q;
  assign bus.hits       = hits_q;
  assign bus.misses     = misses_q;
  assign bus.active     = active_q;
  assign bus.round_done = round_done_q;

endmodule

// File: tb/tb_mole_game_core.sv
// Scoreboard bench for mole_game_core: stimulus pushes expected output values,
// a negedge monitor pops and compares them against the DUT.
module tb_mole_game_core;
  localparam int unsigned N_HOLES = 16;
  localparam int unsigned SCORE_W = 11;
`ifdef MOLE_PENALTY_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  localparam int SEL_MOLES = 0, SEL_ON = 1, SEL_POINTS = 2, SEL_HITS = 3,
                 SEL_MISSES = 4, SEL_ACTIVE = 5, SEL_DONE = 6;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] mask;
    logic [31:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_game;
  logic [15:0] sw;
  logic [15:0] m_lfsr;
  exp_t        sb_q[$];
  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          done_seen = 0;

  always #5 clk = ~clk;

  mole_game_core_if #(.N_HOLES(N_HOLES), .SCORE_W(SCORE_W)) bus ();

  mole_game_core #(
    .N_HOLES(16), .MAX_MOLES(2), .MOLE_LIFE(3), .ROUND_TICKS(30),
    .SCORE_W(11), .HIT_POINTS(1), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk_500hz(clk),
    .rst_game (rst_game),
    .bus      (bus)
  );

  // Reference LFSR, used only to choose when to pulse spawn_tick.
  always @(posedge clk) begin
    if (rst_game) m_lfsr <= 16'hACE1;
    else          m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  function automatic logic [31:0] get_out(input int sel);
    case (sel)
      SEL_MOLES:  return 32'(bus.moles);
      SEL_ON:     return 32'(bus.moles_on);
      SEL_POINTS: return 32'(bus.points);
      SEL_HITS:   return 32'(bus.hits);
      SEL_MISSES: return 32'(bus.misses);
      SEL_ACTIVE: return 32'(bus.active);
      default:    return 32'(bus.round_done);
    endcase
  endfunction

  // Monitor: compare every pending expectation against the settled outputs.
  always @(negedge clk) begin
    if (bus.round_done) done_seen++;
    while (sb_q.size() > 0) begin
      exp_t e;
      logic [31:0] act;
      e   = sb_q.pop_front();
      act = get_out(e.sel) & e.mask;
      total_cnt++;
      if (act == e.val) pass_cnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", e.name, act, e.val, $time);
    end
  end

  task automatic expect_eq(input string name, input int sel, input logic [31:0] val);
    exp_t e;
    e.name = name; e.sel = sel; e.mask = 32'hFFFF_FFFF; e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic expect_bit(input string name, input int b, input logic v);
    exp_t e;
    logic [31:0] m;
    m = 32'd1 << b;
    e.name = name; e.sel = SEL_MOLES; e.mask = m; e.val = v ? m : 32'd0;
    sb_q.push_back(e);
  endtask

  task automatic step(input logic st, input logic tk);
    bus.start      = st;
    bus.spawn_tick = tk;
    bus.switches   = sw;
    @(posedge clk);
    #1;
    bus.start      = 1'b0;
    bus.spawn_tick = 1'b0;
  endtask

  function automatic int cur_idx();
    return int'(m_lfsr[3:0]);
  endfunction

  function automatic logic [15:0] onehot(input int k);
    logic [15:0] one;
    one = 16'd1;
    return one << k;
  endfunction

  task automatic wait_idx_eq(input int t);
    int n = 0;
    while (cur_idx() != t && n < 200) begin step(1'b0, 1'b0); n++; end
    if (n >= 200) begin
      total_cnt++;
      $display("FAIL wait_idx: idx %0d never reached, last %0d", t, cur_idx());
    end
  endtask

  task automatic wait_idx_free(input logic [15:0] lit);
    int n = 0;
    while (lit[m_lfsr[3:0]] && n < 200) begin step(1'b0, 1'b0); n++; end
    if (n >= 200) begin
      total_cnt++;
      $display("FAIL wait_free: no unlit idx for mask 0x%0h", lit);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int a, b, d, x;
    rst_game = 1'b1; sw = 16'h0;
    bus.start = 1'b1; bus.spawn_tick = 1'b0; bus.switches = sw;

    // Reset, with start held: reset wins
    @(posedge clk); @(posedge clk); #1;
    expect_eq("rst_active", SEL_ACTIVE, 0);
    expect_eq("rst_moles", SEL_MOLES, 0);
    expect_eq("rst_points", SEL_POINTS, 0);
    expect_eq("rst_hits", SEL_HITS, 0);
    expect_eq("rst_misses", SEL_MISSES, 0);
    expect_eq("rst_done", SEL_DONE, 0);
    rst_game = 1'b0; bus.start = 1'b0;
    step(1'b0, 1'b1);
    expect_eq("idle_tick_moles", SEL_MOLES, 0);
    expect_eq("idle_active", SEL_ACTIVE, 0);

    // Full round of 30 ticks, switches held
    step(1'b1, 1'b0);
    expect_eq("start_active", SEL_ACTIVE, 1);
    for (int k = 1; k <= 30; k++) begin
      step(1'b0, 1'b1);
      if (k == 29) begin
        expect_eq("t29_active", SEL_ACTIVE, 1);
        expect_eq("t29_done", SEL_DONE, 0);
      end
    end
    expect_eq("t30_done", SEL_DONE, 1);
    expect_eq("t30_active", SEL_ACTIVE, 0);
    expect_eq("t30_moles", SEL_MOLES, 0);
    step(1'b0, 1'b0);
    expect_eq("done_pulse_end", SEL_DONE, 0);
    sw = 16'hFFFF;
    step(1'b0, 1'b1);
    expect_eq("done_points_hold", SEL_POINTS, 0);
    expect_eq("done_hits_hold", SEL_HITS, 0);
    expect_eq("done_moles", SEL_MOLES, 0);

    // Spawn at idx 5 then whack it
    step(1'b1, 1'b0);
    expect_eq("restart_active", SEL_ACTIVE, 1);
    expect_eq("restart_misses", SEL_MISSES, 0);
    wait_idx_eq(5);
    step(1'b0, 1'b1);
    expect_eq("spawn5_moles", SEL_MOLES, 32'h0020);
    expect_eq("spawn5_on", SEL_ON, 1);
    sw = sw ^ onehot(5);
    step(1'b0, 1'b0);
    expect_eq("hit5_moles", SEL_MOLES, 0);
    expect_eq("hit5_points", SEL_POINTS, 1);
    expect_eq("hit5_hits", SEL_HITS, 1);

    // Cap at MAX_MOLES=2, then expiry frees a slot on the same tick
    step(1'b1, 1'b0);
    a = cur_idx();
    step(1'b0, 1'b1);
    expect_eq("cap_a", SEL_MOLES, 32'(onehot(a)));
    wait_idx_free(onehot(a));
    b = cur_idx();
    step(1'b0, 1'b1);
    expect_eq("cap_ab", SEL_MOLES, 32'(onehot(a) | onehot(b)));
    expect_eq("cap_on2", SEL_ON, 2);
    wait_idx_free(onehot(a) | onehot(b));
    step(1'b0, 1'b1);
    expect_eq("cap_blocked", SEL_MOLES, 32'(onehot(a) | onehot(b)));
    expect_eq("cap_blocked_on", SEL_ON, 2);
    wait_idx_free(onehot(a) | onehot(b));
    d = cur_idx();
    step(1'b0, 1'b1);
    expect_eq("expire_respawn", SEL_MOLES, 32'(onehot(b) | onehot(d)));
    expect_eq("expire_misses", SEL_MISSES, 1);
    expect_eq("expire_points", SEL_POINTS, 0);

    // Hole 2 lives three ticks
    step(1'b1, 1'b0);
    x = cur_idx();
    step(1'b0, 1'b1);
    sw = sw ^ onehot(x);
    step(1'b0, 1'b0);
    expect_eq("life_pre_points", SEL_POINTS, 1);
    wait_idx_eq(2);
    step(1'b0, 1'b1);
    expect_bit("life_lit", 2, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    expect_bit("life_age2", 2, 1'b1);
    expect_eq("life_age2_misses", SEL_MISSES, 0);
    step(1'b0, 1'b1);
    expect_bit("life_expired", 2, 1'b0);
    expect_eq("life_misses", SEL_MISSES, 1);
    expect_eq("life_points", SEL_POINTS, PEN ? 0 : 1);

    // Three unlit whacks at zero points
    step(1'b1, 1'b0);
    sw = sw ^ 16'h0007;
    step(1'b0, 1'b0);
    expect_eq("unlit_points", SEL_POINTS, 0);
    expect_eq("unlit_misses", SEL_MISSES, PEN ? 3 : 0);
    expect_eq("unlit_hits", SEL_HITS, 0);

    // Score 7, then restart with a whack on the start cycle
    step(1'b1, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      x = cur_idx();
      step(1'b0, 1'b1);
      expect_eq("score_spawn", SEL_MOLES, 32'(onehot(x)));
      sw = sw ^ onehot(x);
      step(1'b0, 1'b0);
      expect_eq("score_points", SEL_POINTS, 32'(k));
    end
    expect_eq("score7_hits", SEL_HITS, 7);
    sw = sw ^ 16'h0001;
    step(1'b1, 1'b0);
    expect_eq("rs_points", SEL_POINTS, 0);
    expect_eq("rs_hits", SEL_HITS, 0);
    expect_eq("rs_moles", SEL_MOLES, 0);
    step(1'b0, 1'b0);
    expect_eq("rs_late_points", SEL_POINTS, 0);
    expect_eq("rs_late_hits", SEL_HITS, 0);
    for (int k = 1; k <= 30; k++) begin
      step(1'b0, 1'b1);
      if (k == 29) expect_eq("rs_t29_active", SEL_ACTIVE, 1);
    end
    expect_eq("rs_t30_done", SEL_DONE, 1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    total_cnt++;
    if (done_seen == 2) pass_cnt++;
    else $display("FAIL done_count: got %0d round_done pulses expected 2", done_seen);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
